// File: rtl/usb1_rx_pkg.sv
// Shared definitions for the full-speed USB receive front end.
//   - Line-state codes as seen on the synchronised {D+,D-} pair.
//   - Receive FSM state encoding.
//   - SYNC field pattern and the bit-stuffing run length.
package usb1_rx_pkg;

   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_SE1 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_DATA = 3'd2,
      ST_EOP  = 3'd3,
      ST_ERR  = 3'd4
   } rx_state_t;

   // Line level expected at each SYNC strobe, bit i = strobe i (1 = K, 0 = J):
   // K J K J K J K K, which NRZI-decodes to 0000_0001.
   localparam logic [7:0] SYNC_K_MASK = 8'b1101_0101;

   localparam int MAX_ONES = 6;

   function automatic logic sync_level_ok(input logic [2:0] idx, input logic [1:0] ls);
      return ls == (SYNC_K_MASK[idx] ? LS_K : LS_J);
   endfunction

endpackage

// File: rtl/usb1_rx_dpll.sv
// Input synchroniser and bit-timing recovery for the USB receive path.
// Ports:
//   i_clk         system clock (CLK_PER_BIT x bit rate)
//   i_rst_n       synchronous active-low reset
//   i_dp, i_dn    raw pad inputs
//   o_line_state  synchronised {D+,D-}
//   o_strobe      one-cycle sample strobe near the centre of each bit
module usb1_rx_dpll
   import usb1_rx_pkg::*;
#(
   parameter int CLK_PER_BIT = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_dp,
   input  logic       i_dn,
   output logic [1:0] o_line_state,
   output logic       o_strobe
);

   localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [PW-1:0] PH_LAST   = PW'(CLK_PER_BIT - 1);
   localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_PER_BIT / 2);

   logic [SYNC_STAGES-1:0][1:0] r_sync;
   logic [PW-1:0]               r_phase;
   logic                        w_change;

   // The last stage is about to take a new value: restart the bit phase so
   // the sample point lands CLK_PER_BIT/2 clocks after every line transition.
   assign w_change = r_sync[SYNC_STAGES-1] != r_sync[SYNC_STAGES-2];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync  <= {SYNC_STAGES{LS_J}};
         r_phase <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], {i_dp, i_dn}};
         if (w_change || r_phase == PH_LAST) begin
            r_phase <= '0;
         end else begin
            r_phase <= r_phase + 1'b1;
         end
      end
   end

   assign o_line_state = r_sync[SYNC_STAGES-1];
   assign o_strobe     = (r_phase == PH_SAMPLE);

endmodule

// File: rtl/usb1_rx_frontend.sv
// Full-speed USB 1.1 receive front end: NRZI decode, bit unstuffing, SYNC and
// EOP detection, byte assembly.
// Ports:
//   clk_i         system clock (48 MHz for 12 Mb/s)
//   rst_i         synchronous active-low reset
//   dp_i, dn_i    raw D+/D- from the pad
//   rx_en_i       receive enable (low while the transmitter owns the bus)
//   line_state_o  synchronised {D+,D-}
//   rx_data_o     received byte, valid while rx_valid_o is high
//   rx_valid_o    one-cycle byte strobe
//   rx_active_o   high from SYNC completion until EOP/abort
//   rx_error_o    one-cycle stuff/SE1/alignment error strobe
module usb1_rx_frontend
   import usb1_rx_pkg::*;
#(
   parameter int CLK_PER_BIT = 4,
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_J_BITS = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       dp_i,
   input  logic       dn_i,
   input  logic       rx_en_i,
   output logic [1:0] line_state_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_active_o,
   output logic       rx_error_o
);

   localparam int JW = $clog2(IDLE_J_BITS + 1);

   logic [1:0]    w_ls;
   logic          w_strobe;
   logic          w_bit;

   rx_state_t     r_state;
   logic [1:0]    r_prev_lvl;
   logic [2:0]    r_ones;
   logic [6:0]    r_shift;
   logic [2:0]    r_bitcnt;
   logic [2:0]    r_sync_idx;
   logic [JW-1:0] r_jcnt;
   logic          r_se0_seen;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_active;
   logic          r_error;

   usb1_rx_dpll #(
      .CLK_PER_BIT(CLK_PER_BIT),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_dpll (
      .i_clk       (clk_i),
      .i_rst_n     (rst_i),
      .i_dp        (dp_i),
      .i_dn        (dn_i),
      .o_line_state(w_ls),
      .o_strobe    (w_strobe)
   );

   // NRZI: no transition means a 1.
   assign w_bit = (w_ls == r_prev_lvl);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state    <= ST_IDLE;
         r_prev_lvl <= LS_J;
         r_ones     <= '0;
         r_shift    <= '0;
         r_bitcnt   <= '0;
         r_sync_idx <= '0;
         r_jcnt     <= '0;
         r_se0_seen <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_active   <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         if (w_strobe) begin
            r_prev_lvl <= w_ls;
         end
         if (!rx_en_i) begin
            // Transmitter owns the bus: silent abort.
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_ones   <= '0;
            r_bitcnt <= '0;
         end else if (w_strobe) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_ls == LS_K) begin
                     r_state    <= ST_SYNC;
                     r_sync_idx <= 3'd1;
                  end
               end
               ST_SYNC: begin
                  if (!sync_level_ok(r_sync_idx, w_ls)) begin
                     r_state <= ST_IDLE;
                  end else if (r_sync_idx == 3'd7) begin
                     r_state  <= ST_DATA;
                     r_active <= 1'b1;
                     r_ones   <= '0;
                     r_bitcnt <= '0;
                  end else begin
                     r_sync_idx <= r_sync_idx + 3'd1;
                  end
               end
               ST_DATA: begin
                  if (w_ls == LS_SE0) begin
                     r_state <= ST_EOP;
                     // Packet ended mid-byte: alignment error.
                     r_error <= (r_bitcnt != 3'd0);
                  end else if (w_ls == LS_SE1) begin
                     r_state    <= ST_ERR;
                     r_error    <= 1'b1;
                     r_se0_seen <= 1'b0;
                     r_jcnt     <= '0;
                  end else if (r_ones == 3'(MAX_ONES)) begin
                     if (w_bit) begin
                        r_state    <= ST_ERR;
                        r_error    <= 1'b1;
                        r_se0_seen <= 1'b0;
                        r_jcnt     <= '0;
                     end else begin
                        // Stuffed zero: dropped, not part of the byte.
                        r_ones <= '0;
                     end
                  end else begin
                     r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
                     r_shift  <= {w_bit, r_shift[6:1]};
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (r_bitcnt == 3'd7) begin
                        r_data  <= {w_bit, r_shift};
                        r_valid <= 1'b1;
                     end
                  end
               end
               ST_EOP: begin
                  if (w_ls == LS_J) begin
                     r_state  <= ST_IDLE;
                     r_active <= 1'b0;
                  end
               end
               ST_ERR: begin
                  if (w_ls == LS_SE0) begin
                     r_se0_seen <= 1'b1;
                     r_jcnt     <= '0;
                  end else if (w_ls == LS_J) begin
                     if (r_se0_seen || r_jcnt == JW'(IDLE_J_BITS - 1)) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                     end else begin
                        r_jcnt <= r_jcnt + 1'b1;
                     end
                  end else begin
                     // K or SE1 breaks both the SE0-J sequence and the J run.
                     r_se0_seen <= 1'b0;
                     r_jcnt     <= '0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign line_state_o = w_ls;
   assign rx_data_o    = r_data;
   assign rx_valid_o   = r_valid;
   assign rx_active_o  = r_active;
   assign rx_error_o   = r_error;

endmodule

// File: tb/tb_usb1_rx_frontend.sv
// Bench for usb1_rx_frontend: packets are built by a transmit-side encoder
// (bytes -> bit stuffing -> NRZI line levels), and the receiver's byte and
// error strobes are scored against the event queue filled by that encoder.
module tb_usb1_rx_frontend;

   localparam logic [1:0] BSE0 = 2'b00;
   localparam logic [1:0] BK   = 2'b01;
   localparam logic [1:0] BJ   = 2'b10;
   localparam int EV_ERR = 256;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dp = 1'b1;
   logic       dn = 1'b0;
   logic       rx_en = 1'b1;
   logic [1:0] line_state;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_active;
   logic       rx_error;

   usb1_rx_frontend #(
      .CLK_PER_BIT(4),
      .SYNC_STAGES(2),
      .IDLE_J_BITS(8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .dp_i        (dp),
      .dn_i        (dn),
      .rx_en_i     (rx_en),
      .line_state_o(line_state),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .rx_active_o (rx_active),
      .rx_error_o  (rx_error)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   int last_rise = -1, last_fall = -1, last_valid = -1, n_rise = 0;
   logic prev_act = 1'b0;
   int e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Scoreboard: every byte/error strobe must match the next expected event.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid || rx_error) chk("valid_error_overlap", 32'(rx_valid & rx_error), 0);
         if (rx_valid) begin
            last_valid = cyc;
            chk("active_with_valid", 32'(rx_active), 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            chk("rx_byte", {24'd0, rx_data}, e);
         end
         if (rx_error) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            chk("rx_error_event", {23'd0, rx_error, 8'd0}, e);
         end
         if (rx_active && !prev_act) begin
            last_rise = cyc;
            n_rise++;
         end
         if (!rx_active && prev_act) last_fall = cyc;
      end
      prev_act = rx_active;
   end

   // Transmit-side packet builder.
   logic [1:0] lv_q[$];
   logic [1:0] cur;
   int ones, sidx = -1, jidx = -1;
   int t0, t8, tj;

   function automatic logic [1:0] flip(input logic [1:0] l);
      return (l == BJ) ? BK : BJ;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) lv_q.push_back(BJ);
   endtask

   task automatic start_pkt();
      idle(4);
      sidx = lv_q.size();
      jidx = -1;
      lv_q.push_back(BK); lv_q.push_back(BJ); lv_q.push_back(BK); lv_q.push_back(BJ);
      lv_q.push_back(BK); lv_q.push_back(BJ); lv_q.push_back(BK); lv_q.push_back(BK);
      cur = BK;
      ones = 0;
   endtask

   task automatic raw_bit(input bit b);
      if (!b) cur = flip(cur);
      lv_q.push_back(cur);
   endtask

   task automatic enc_bit(input bit b);
      raw_bit(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
         raw_bit(1'b0);
         ones = 0;
      end
   endtask

   task automatic enc_byte(input logic [7:0] v, input bit expect_it);
      for (int i = 0; i < 8; i++) enc_bit(v[i]);
      if (expect_it) exp_q.push_back(int'(v));
   endtask

   task automatic end_pkt();
      lv_q.push_back(BSE0);
      lv_q.push_back(BSE0);
      jidx = lv_q.size();
      lv_q.push_back(BJ);
      cur = BJ;
      idle(10);
   endtask

   function automatic int per(input int mode, input int par, input int i);
      if (mode == 0) return 4;
      return (((i + par) % 2) == 0) ? 3 : 5;
   endfunction

   task automatic play(input int mode, input int par, input int drop_at, input int rst_at);
      bit aborted = 1'b0;
      for (int i = 0; i < lv_q.size(); i++) begin
         if (i == drop_at) begin
            chk("active_before_drop", 32'(rx_active), 1);
            rx_en = 1'b0;
            @(posedge clk); #1;
            chk("active_after_drop", 32'(rx_active), 0);
            aborted = 1'b1;
         end
         if (i == rst_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("rst_line_state", 32'(line_state), 2);
            chk("rst_data", 32'(rx_data), 0);
            chk("rst_valid", 32'(rx_valid), 0);
            chk("rst_active", 32'(rx_active), 0);
            chk("rst_error", 32'(rx_error), 0);
            rst_n = 1'b1;
            {dp, dn} = BJ;
            aborted = 1'b1;
            break;
         end
         if (i == sidx) t0 = cyc;
         if (i == sidx + 8) t8 = cyc;
         if (i == jidx && !aborted) begin
            chk("active_at_eop_j", 32'(rx_active), 1);
            tj = cyc;
         end
         {dp, dn} = lv_q[i];
         repeat (per(mode, par, i)) @(posedge clk);
         #1;
      end
      if (aborted) begin
         {dp, dn} = BJ;
         repeat (40) @(posedge clk);
         #1;
         rx_en = 1'b1;
         repeat (4) @(posedge clk);
         #1;
      end
      if (!aborted && jidx >= 0) chk("active_fall_latency", last_fall - tj, 5);
      chk("active_idle", 32'(rx_active), 0);
      chk("queue_empty", exp_q.size(), 0);
      lv_q.delete();
      sidx = -1;
      jidx = -1;
   endtask

   initial begin
      int mode, par, nb, nx, rises;
      logic [7:0] v;

      // Reset with K on the pins: synchroniser must still read J.
      rst_n = 1'b0;
      {dp, dn} = BK;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_line_state", 32'(line_state), 2);
      chk("reset_data", 32'(rx_data), 0);
      chk("reset_valid", 32'(rx_valid), 0);
      chk("reset_active", 32'(rx_active), 0);
      chk("reset_error", 32'(rx_error), 0);
      {dp, dn} = BJ;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // 0xA5 at nominal timing, with hand-computed latencies.
      start_pkt(); enc_byte(8'hA5, 1); end_pkt();
      play(0, 0, -1, -1);
      chk("active_rise_latency", last_rise - t0, 33);
      chk("valid_latency", last_valid - t8, 33);

      // Stuffed bytes.
      start_pkt(); enc_byte(8'hFF, 1); enc_byte(8'h3F, 1); end_pkt();
      play(0, 0, -1, -1);

      // Seven consecutive ones: stuff error, held active until SE0 then J.
      start_pkt();
      for (int i = 0; i < 7; i++) raw_bit(1'b1);
      exp_q.push_back(EV_ERR);
      end_pkt();
      play(0, 0, -1, -1);

      // Byte followed by 3 stray bits: alignment error on EOP.
      start_pkt(); enc_byte(8'h12, 1);
      enc_bit(1'b1); enc_bit(1'b0); enc_bit(1'b1);
      exp_q.push_back(EV_ERR);
      end_pkt();
      play(0, 0, -1, -1);

      // Bad SYNC: no activity at all.
      rises = n_rise;
      idle(4);
      lv_q.push_back(BK); lv_q.push_back(BJ); lv_q.push_back(BK); lv_q.push_back(BJ);
      lv_q.push_back(BJ);
      idle(10);
      play(0, 0, -1, -1);
      chk("bad_sync_no_active", n_rise - rises, 0);

      // Receive disable after 4 data bits: silent abort.
      start_pkt(); enc_byte(8'hC3, 0); enc_byte(8'h7E, 0); end_pkt();
      play(0, 0, sidx + 12, -1);

      // Alternating 3/5-clock bit periods.
      start_pkt(); enc_byte(8'h5A, 1); end_pkt();
      play(1, 0, -1, -1);

      // Reset in the middle of a byte.
      start_pkt(); enc_byte(8'h96, 0); end_pkt();
      play(1, 1, -1, sidx + 11);

      // Random packets.
      for (int n = 0; n < 30; n++) begin
         mode = int'($urandom_range(0, 1));
         par  = int'($urandom_range(0, 1));
         nb   = int'($urandom_range(1, 4));
         start_pkt();
         for (int b = 0; b < nb; b++) begin
            v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            enc_byte(v, 1);
         end
         if ($urandom_range(0, 4) == 0) begin
            nx = int'($urandom_range(1, 7));
            for (int b = 0; b < nx; b++) enc_bit(1'($urandom_range(0, 1)));
            exp_q.push_back(EV_ERR);
         end
         end_pkt();
         play(mode, par, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
